// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-requester arbiter with fixed-priority or round-robin policy,
// zero-bubble handoff between owners and an optional hold-time limit that
// preempts an owner which keeps the grant for MAX_HOLD consecutive cycles.
// All outputs come from flops; nothing on req reaches an output combinationally.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N-1:0]                      req,
  output logic [N-1:0]                      gnt,
  output logic                              gnt_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
  output logic                              preempt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            preempt_q, preempt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic [IW-1:0]   start_s;
  logic            owner_req_s;
  logic            expired_s;
  logic [N-1:0]    masked_req_s;
  logic            found_s;
  logic [IW-1:0]   win_s;
  logic            load_s;
  logic            idle_s;
  logic [IW-1:0]   load_id_s;

  // Search r starting at index 'start', wrapping N-1 -> 0; returns {found, index}.
  function automatic logic [IW:0] pick(input logic [N-1:0] r, input logic [IW-1:0] start);
    logic          found;
    logic [IW-1:0] win;
    logic [IW:0]   j;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, start} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) begin
        j = j - (IW+1)'(N);
      end else begin
        j = j;
      end
      if (!found && r[j[IW-1:0]]) begin
        found = 1'b1;
        win   = j[IW-1:0];
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Arbitration inputs: search origin, expiry detection and owner masking.
  always_comb begin
    start_s      = (MODE == 1) ? ptr_q : '0;
    owner_req_s  = req[gnt_id_q];
    expired_s    = (MAX_HOLD > 0) && (state_q == ST_GRANT) && owner_req_s &&
                   (hold_cnt_q == HW'(MAX_HOLD));
    masked_req_s = req;
    if (expired_s) begin
      masked_req_s[gnt_id_q] = 1'b0;
    end else begin
      masked_req_s = req;
    end
    {found_s, win_s} = pick(masked_req_s, start_s);
  end

  // Next-state: decide keep / load new owner / go idle, then build the next register values.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    preempt_d   = 1'b0;
    load_s      = 1'b0;
    idle_s      = 1'b0;
    load_id_s   = win_s;

    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          load_s = 1'b1;
        end else begin
          idle_s = 1'b1;
        end
      end
      ST_GRANT: begin
        if (owner_req_s && !expired_s) begin
          // Owner keeps the grant; count saturates at the limit.
          if ((MAX_HOLD > 0) && (hold_cnt_q != HW'(MAX_HOLD))) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end else if (expired_s && !found_s) begin
          // Limit reached but nobody else wants it: re-grant the same owner.
          load_s    = 1'b1;
          load_id_s = gnt_id_q;
        end else if (found_s) begin
          // Handoff on this edge; flag a preemption if the owner still wanted it.
          load_s    = 1'b1;
          preempt_d = expired_s;
        end else begin
          idle_s = 1'b1;
        end
      end
      default: begin
        idle_s = 1'b1;
      end
    endcase

    if (load_s) begin
      state_d            = ST_GRANT;
      gnt_d              = '0;
      gnt_d[load_id_s]   = 1'b1;
      gnt_id_d           = load_id_s;
      hold_cnt_d         = (MAX_HOLD > 0) ? HW'(1) : '0;
      if (MODE == 1) begin
        ptr_d = (load_id_s == IW'(N - 1)) ? '0 : load_id_s + IW'(1);
      end else begin
        ptr_d = '0;
      end
    end else if (idle_s) begin
      state_d    = ST_IDLE;
      gnt_d      = '0;
      gnt_id_d   = '0;
      hold_cnt_d = '0;
    end else begin
      state_d = state_d;
    end

    gnt_valid_d = (state_d == ST_GRANT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
- Parametrised N-requester arbiter; successor to the fixed 4-way grant-and-hold arbiter.
- Adds selectable fixed-priority or round-robin policy and zero-bubble handoff.
- Adds an optional hold-time limit that preempts a requester holding the grant too long.
- Sits in front of a shared resource (bus, memory port); grant outputs are registered and one-hot.

Parameters:
- N, 4, number of requesters (2..32).
- MODE, 0, arbitration policy: 0 = fixed priority (index 0 highest), 1 = round-robin.
- MAX_HOLD, 0, maximum consecutive grant cycles per ownership; 0 = unlimited (hold while requesting).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  N  request vector; bit i = requester i.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_valid  out  1  registered; high when any gnt bit is high (equals OR of gnt).
- gnt_id  out  max(1,clog2(N))  registered index of the granted requester; 0 when gnt_valid=0.
- preempt  out  1  registered 1-cycle pulse: the previous grant was ended by hold-limit expiry while the owner was still requesting.

Behaviour:
- Reset: on any edge with rst=1: gnt=0, gnt_valid=0, gnt_id=0, preempt=0, hold_cnt=0, RR pointer=0 (requester 0 highest priority). This applies mid-grant too; the grant drops on the same edge.
- States:
  - IDLE (gnt_valid=0).
  - GRANT (gnt_valid=1, owner=gnt_id).
- Each rising edge (rst=0):
  - GRANT, req[owner]=1, not expired: keep owner; hold_cnt++ (saturating); preempt=0.
  - GRANT, req[owner]=0: arbitrate over req; the winner (or IDLE if none) is loaded on this same edge. There is no idle bubble between owners.
  - GRANT, expired (MAX_HOLD>0, hold_cnt==MAX_HOLD, req[owner]=1): arbitrate over req with the owner bit masked.
    - If another requester wins: switch to it and pulse preempt=1.
    - If no other requester: owner re-granted, hold_cnt reloaded to 1, preempt=0.
  - IDLE: arbitrate over req; the winner (if any) is loaded. Latency from request to grant is 1 edge.
- Arbitration:
  - MODE 0: lowest set index wins.
  - MODE 1: first set index at or after the pointer, wrapping N-1 -> 0, wins. On every new grant to index k, the pointer becomes (k+1) mod N. A re-grant to the same owner after expiry also advances the pointer.
- hold_cnt:
  - Width clog2(MAX_HOLD+1) (min 1); set to 1 on every new grant, including re-grant.
  - Unused (held 0) when MAX_HOLD=0.
- Output invariants:
  - gnt is always one-hot or zero; never more than one bit.
  - gnt_id, gnt_valid and gnt change on the same edge.
- No combinational path from req to any output.
- A requester dropping and re-raising req between edges is invisible; only sampled values matter.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0 throughout. Release rst -> gnt=4'b0001 after the next edge (MODE 0).
- Fixed priority hold (N=4, MODE 0, MAX_HOLD=0): req=4'b1100 -> gnt=4'b0100, gnt_id=2. Raise req[0] while req[2] is held -> gnt stays 4'b0100. Drop req[2] -> next edge gnt=4'b0001 with no zero cycle.
- Round-robin rotation (MODE 1): req=4'b1111 constant, each owner drops its req for one sampled edge after 1 cycle -> grant sequence 0,1,2,3,0. After reset, req=4'b1000 -> gnt_id=3, pointer 0; then req=4'b1001 with req[3] dropped -> gnt_id=0.
- Hold limit (MODE 1, MAX_HOLD=3): req=4'b0011 held constant -> gnt=4'b0001 for exactly 3 cycles, then gnt=4'b0010 with preempt=1 for 1 cycle; afterwards alternates every 3 cycles.
- Lone requester at limit (MAX_HOLD=2): req=4'b0100 only -> gnt=4'b0100 continuously, preempt never asserted, hold_cnt cycles 1,2,1,2.
- Reset mid-grant (MODE 1, owner=2, pointer=3): assert rst one cycle with req=4'b0110 -> gnt=0 on that edge. Next edge gnt_id=1, proving the pointer was reset to 0.
